// File: rtl/bram_initiator_if.sv
// Command/response stream bundle for bram_initiator.
//   cmd_*  : read/write commands, valid/ready handshake (client -> initiator)
//   rsp_*  : read responses with their address, valid/ready handshake (initiator -> client)
// Modports:
//   master : client side (drives commands, consumes responses)
//   slave  : bram_initiator side
interface bram_initiator_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ADDR_WIDTH-1:0] rsp_addr;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_addr, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_addr, rsp_data
    );
endinterface

// File: rtl/bram_initiator.sv
// Initiator for the single-port capture BRAM (xilinx_bram).
// Accepts read/write commands on a valid/ready stream, issues them to the BRAM one per cycle in
// accept order, and returns read data tagged with its address through a first-word-fall-through
// response FIFO. A credit rule (reads in flight + queued responses < RSP_DEPTH) keeps the FIFO
// from ever overflowing.
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   stream (slave)   : cmd_* command stream in, rsp_* response stream out
//   bram_write_en, bram_read_en, bram_addr, bram_write_data : to xilinx_bram
//   bram_read_data, bram_valid                              : from xilinx_bram
//   busy             : reads in flight, responses queued, or clear running
//   err_unexpected   : sticky, bram_valid arrived with no read in flight
//
// Configuration macro BRAM_INITIATOR_CLEAR_EN: when defined, every reset is followed by an INIT
// pass writing zero to all 2^ADDR_WIDTH addresses before commands are accepted.
module bram_initiator #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    bram_initiator_if.slave       stream,
    output logic                  bram_write_en,
    output logic                  bram_read_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_write_data,
    input  logic [DATA_WIDTH-1:0] bram_read_data,
    input  logic                  bram_valid,
    output logic                  busy,
    output logic                  err_unexpected
);

    localparam int unsigned PtrW = $clog2(RSP_DEPTH);
    localparam int unsigned CntW = (PtrW + 1 < 3) ? 3 : PtrW + 1;

    typedef enum logic [0:0] {StInit, StRun} state_e;

`ifdef BRAM_INITIATOR_CLEAR_EN
    localparam state_e ResetState = StInit;
`else
    localparam state_e ResetState = StRun;
`endif

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;

    logic [CntW-1:0]       inflight_q, inflight_d;
    logic [CntW-1:0]       rsp_cnt_q, rsp_cnt_d;
    logic [CntW:0]         credit_used;

    // Tag FIFO holds the addresses of reads issued but not yet returned.
    logic [ADDR_WIDTH-1:0] tag_mem [RSP_DEPTH];
    logic [PtrW-1:0]       tag_wr_q, tag_rd_q;

    logic [ADDR_WIDTH-1:0] rsp_addr_mem [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] rsp_data_mem [RSP_DEPTH];
    logic [PtrW-1:0]       rsp_wr_q, rsp_rd_q;

    logic                  we_q, re_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  err_q;

    logic accept, rd_accept, rsp_push, rsp_pop;

    // Reads and writes share one credit pool; ready never looks at cmd_valid or cmd_write.
    assign credit_used      = {1'b0, inflight_q} + {1'b0, rsp_cnt_q};
    assign stream.cmd_ready = (state_q == StRun) && (credit_used < (CntW + 1)'(RSP_DEPTH));

    assign accept    = stream.cmd_valid && stream.cmd_ready;
    assign rd_accept = accept && !stream.cmd_write;
    assign rsp_push  = bram_valid && (inflight_q != '0);
    assign rsp_pop   = stream.rsp_valid && stream.rsp_ready;

    assign stream.rsp_valid = (rsp_cnt_q != '0);
    assign stream.rsp_addr  = rsp_addr_mem[rsp_rd_q];
    assign stream.rsp_data  = rsp_data_mem[rsp_rd_q];

    // During INIT the clear sweep drives the BRAM directly from the address counter.
    assign bram_write_en   = (state_q == StInit) || we_q;
    assign bram_read_en    = re_q;
    assign bram_addr       = (state_q == StInit) ? init_addr_q : addr_q;
    assign bram_write_data = (state_q == StInit) ? '0 : wdata_q;

    assign busy           = (inflight_q != '0) || (rsp_cnt_q != '0) || (state_q == StInit);
    assign err_unexpected = err_q;

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        if (state_q == StInit) begin
            init_addr_d = init_addr_q + 1'b1;
            if (init_addr_q == '1) begin
                state_d = StRun;
            end
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        unique case ({rd_accept, rsp_push})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        rsp_cnt_d = rsp_cnt_q;
        unique case ({rsp_push, rsp_pop})
            2'b10:   rsp_cnt_d = rsp_cnt_q + 1'b1;
            2'b01:   rsp_cnt_d = rsp_cnt_q - 1'b1;
            default: rsp_cnt_d = rsp_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ResetState;
            init_addr_q <= '0;
            inflight_q  <= '0;
            rsp_cnt_q   <= '0;
            tag_wr_q    <= '0;
            tag_rd_q    <= '0;
            rsp_wr_q    <= '0;
            rsp_rd_q    <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            inflight_q  <= inflight_d;
            rsp_cnt_q   <= rsp_cnt_d;
            we_q        <= accept && stream.cmd_write;
            re_q        <= rd_accept;
            if (accept) begin
                addr_q  <= stream.cmd_addr;
                wdata_q <= stream.cmd_wdata;
            end
            if (rd_accept) begin
                tag_wr_q <= tag_wr_q + 1'b1;
            end
            if (rsp_push) begin
                tag_rd_q <= tag_rd_q + 1'b1;
                rsp_wr_q <= rsp_wr_q + 1'b1;
            end
            if (rsp_pop) begin
                rsp_rd_q <= rsp_rd_q + 1'b1;
            end
            // Data returned with nothing outstanding is dropped, only flagged.
            if (bram_valid && (inflight_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Storage arrays carry no reset; pointers and counts define their contents.
    always_ff @(posedge clk) begin
        if (rd_accept) begin
            tag_mem[tag_wr_q] <= stream.cmd_addr;
        end
        if (rsp_push) begin
            rsp_addr_mem[rsp_wr_q] <= tag_mem[tag_rd_q];
            rsp_data_mem[rsp_wr_q] <= bram_read_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_fifo_no_overflow: assert (!(rsp_push && (rsp_cnt_q == CntW'(RSP_DEPTH))));
        end
    end

endmodule

// File: tb/tb_bram_initiator.sv
module tb_bram_initiator;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
`ifdef BRAM_INITIATOR_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    logic          bram_we, bram_re, bram_valid, busy, err;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata, bram_rdata;

    bram_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .stream          (bus.slave),
        .bram_write_en   (bram_we),
        .bram_read_en    (bram_re),
        .bram_addr       (bram_addr),
        .bram_write_data (bram_wdata),
        .bram_read_data  (bram_rdata),
        .bram_valid      (bram_valid),
        .busy            (busy),
        .err_unexpected  (err)
    );

    // BRAM model: 2-cycle read latency, unwritten locations read as 0xBEEF.
    logic [DW-1:0] mem [2**AW];
    bit            written [2**AW];
    bit            v1, v2;
    logic [DW-1:0] d1, d2;
    bit            force_v;
    logic [DW-1:0] force_d;

    always @(posedge clk) begin
        if (bram_we) begin
            mem[bram_addr]     <= bram_wdata;
            written[bram_addr] <= 1'b1;
        end
        v1 <= bram_re;
        d1 <= written[bram_addr] ? mem[bram_addr] : 16'hBEEF;
        v2 <= v1;
        d2 <= d1;
    end
    assign bram_valid = v2 | force_v;
    assign bram_rdata = force_v ? force_d : d2;

    typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} rsp_t;
    typedef struct packed {logic w; logic [AW-1:0] a; logic [DW-1:0] d;} iss_t;
    typedef struct {bit write; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] exp;} vec_t;

    rsp_t exp_q[$];
    iss_t iss_q[$];
    int   checks = 0;
    int   errors = 0;
    int   accepted = 0;
    int   rsp_cnt = 0;
    bit   init_window = 1'b0;

    task automatic fail(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Response scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                fail("rsp_unexpected", {bus.rsp_addr, bus.rsp_data}, 64'h0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp", {bus.rsp_addr, bus.rsp_data}, e);
                rsp_cnt++;
            end
        end
    end

    // Issue-order scoreboard on the BRAM side.
    always @(negedge clk) begin
        if (!rst && !init_window && (bram_we || bram_re)) begin
            if (iss_q.size() == 0) begin
                fail("issue_unexpected", {bram_we, bram_re, bram_addr}, 64'h0);
            end else begin
                iss_t e;
                e = iss_q.pop_front();
                chk("issue", {bram_we, bram_re, bram_addr, bram_we ? bram_wdata : 16'h0},
                    {e.w, ~e.w, e.a, e.w ? e.d : 16'h0});
            end
        end
    end

    task automatic send(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] e);
        int waitc = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        while (!bus.cmd_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.cmd_ready) begin
            fail("cmd_timeout", 64'(a), 64'h1);
            bus.cmd_valid = 1'b0;
            return;
        end
        iss_q.push_back({w, a, d});
        if (!w) exp_q.push_back({a, e});
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        accepted++;
    endtask

    task automatic wait_ready();
        int c = 0;
        @(negedge clk);
        while (!bus.cmd_ready && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk("ready_after_reset", 64'(bus.cmd_ready), 64'h1);
        init_window = 1'b0;
    endtask

    task automatic do_reset();
        int n = 0;
        rst = 1'b1;
        init_window = CLR;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        iss_q.delete();
        if (CLR) begin
            // Count the clear sweep: zero written to consecutive addresses until ready rises.
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                if (bus.cmd_ready) break;
                if (bram_we && bram_addr == AW'(n) && bram_wdata == '0) n++;
            end
            chk("init_writes", 64'(n), 64'(2**AW));
            init_window = 1'b0;
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) fail("drain_timeout", 64'(exp_q.size()), 64'h0);
    endtask

    vec_t          vecs [12];
    logic [AW-1:0] t3_addr [6];
    logic [DW-1:0] t3_exp  [6];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        for (int i = 0; i < 5; i++) begin
            vecs[i]     = '{1'b1, AW'(i), 16'hA000 + 16'(i), 16'h0};
            vecs[5 + i] = '{1'b0, AW'(i), 16'h0, 16'hA000 + 16'(i)};
            t3_addr[i]  = AW'(i);
            t3_exp[i]   = 16'hA000 + 16'(i);
        end
        vecs[10]   = '{1'b1, 10'h03A, 16'h1234, 16'h0};
        vecs[11]   = '{1'b0, 10'h03A, 16'h0, 16'h1234};
        t3_addr[5] = 10'h03A;
        t3_exp[5]  = 16'h1234;

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;
        force_v = 1'b0;
        force_d = '0;

        do_reset();
        @(negedge clk);
        chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'h1);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_err", 64'(err), 64'h0);
        chk("reset_bram_en", {bram_we, bram_re}, 64'h0);

        // Writes then reads of 0..4, then write/read 0x3A back to back.
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
        end
        drain();
        chk("t1_err", 64'(err), 64'h0);

        // Back-pressure: only DEPTH reads accepted while responses are held.
        bus.rsp_ready = 1'b0;
        accepted = 0;
        r0 = rsp_cnt;
        fork
            begin
                for (int i = 0; i < 6; i++) send(1'b0, t3_addr[i], 16'h0, t3_exp[i]);
            end
            begin
                repeat (12) @(negedge clk);
                chk("t3_accepted", 64'(accepted), 64'(DEPTH));
                chk("t3_cmd_ready", 64'(bus.cmd_ready), 64'h0);
                chk("t3_rsp_valid", 64'(bus.rsp_valid), 64'h1);
                @(posedge clk);
                #1 bus.rsp_ready = 1'b1;
            end
        join
        drain();
        chk("t3_returned", 64'(rsp_cnt - r0), 64'h6);

        // Unexpected bram_valid.
        @(negedge clk);
        force_d = 16'hDEAD;
        force_v = 1'b1;
        @(posedge clk);
        #1 force_v = 1'b0;
        @(negedge clk);
        chk("t4_err_set", 64'(err), 64'h1);
        chk("t4_fifo_empty", 64'(bus.rsp_valid), 64'h0);
        repeat (5) @(negedge clk);
        chk("t4_err_sticky", 64'(err), 64'h1);

        // Reset with two reads in flight.
        send(1'b0, 10'h001, 16'h0, 16'hA001);
        send(1'b0, 10'h002, 16'h0, 16'hA002);
        rst = 1'b1;
        init_window = CLR;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        iss_q.delete();
        @(negedge clk);
        chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        chk("t5_busy", 64'(busy), 64'(CLR));
        chk("t5_err_cleared", 64'(err), 64'h0);
        @(negedge clk);
        chk("t5_late_valid_err", 64'(err), 64'h1);
        chk("t5_rsp_valid_late", 64'(bus.rsp_valid), 64'h0);
        if (CLR) wait_ready();

        // Clean restart; with the clear build every location reads back zero.
        do_reset();
        chk("final_err", 64'(err), 64'h0);
        send(1'b0, 10'h03A, 16'h0, CLR ? 16'h0000 : 16'h1234);
        send(1'b0, 10'h3FF, 16'h0, CLR ? 16'h0000 : 16'hBEEF);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
